vector_issue_controller: RTL and testbench

- In-order issue stage in front of the vector processor datapath (`top`).
- Accepts decoded instructions over a valid/ready handshake and tracks pending register writebacks in a per-register scoreboard.
- Stalls on RAW/WAW hazards, then drives registered ID_* fields into the datapath.
- Supports a flush/drain request and counts stall cycles.

---
 rtl/vector_issue_controller.sv | 180 ++++++++++++++++++
 tb/tb_vector_issue_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_issue_controller.sv
// In-order issue stage: per-register writeback scoreboard, RAW/WAW stall,
// one-cycle registered issue into the datapath, flush/drain and stall counter.
module vector_issue_controller #(
   parameter int WB_LATENCY = 3,
   parameter int STALL_W    = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4:0]         in_vs,
   input  logic [4:0]         in_vt,
   input  logic [4:0]         in_vd,
   input  logic [11:0]        in_shamt,
   input  logic [4:0]         in_op,
   input  logic [15:0]        in_imm16,
   input  logic [31:0]        in_mov_data,
   input  logic [31:0]        in_mem_dir,
   input  logic               flush,
   output logic [4:0]         ID_VS,
   output logic [4:0]         ID_VT,
   output logic [4:0]         ID_VD,
   output logic [11:0]        ID_SHAMT,
   output logic [4:0]         ID_OP,
   output logic [15:0]        ID_IMM16,
   output logic [31:0]        register_mov_data,
   output logic [31:0]        data_memory_direction,
   output logic               issue_valid,
   output logic               flush_done,
   output logic [STALL_W-1:0] stall_count
);

   localparam int CW = $clog2(WB_LATENCY + 1);
   localparam logic [4:0] OP_NOP = 5'b00000;
   localparam logic [4:0] OP_MOV = 5'b00100;

   typedef enum logic {ST_RUN, ST_DRAIN} state_t;

   state_t             state_q, state_d;
   logic               flush_done_q, flush_done_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               issue_valid_q, issue_valid_d;
   logic [4:0]         id_vs_q, id_vs_d, id_vt_q, id_vt_d, id_vd_q, id_vd_d;
   logic [4:0]         id_op_q, id_op_d;
   logic [11:0]        id_shamt_q, id_shamt_d;
   logic [15:0]        id_imm_q, id_imm_d;
   logic [31:0]        mov_q, mov_d, mem_q, mem_d;

   logic [31:0] busy;
   logic        hazard, accept, load_en, all_zero;

   // Scoreboard: one down-counter per register, a fresh load beats the decrement.
   for (genvar gi = 0; gi < 32; gi++) begin : g_sb
      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = '0;
         if (load_en && in_vd == 5'(gi)) begin
            cnt_d = CW'(WB_LATENCY);
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign busy[gi] = |cnt_q;
   end

   assign all_zero = ~|busy;

   // MOV only writes; NOP touches nothing; everything else reads VS/VT.
   always_comb begin
      hazard = 1'b0;
      if (in_op != OP_NOP) begin
         hazard = busy[in_vd];
         if (in_op != OP_MOV) begin
            hazard = hazard | busy[in_vs] | busy[in_vt];
         end
      end
   end

   assign in_ready = (state_q == ST_RUN) && !hazard;
   assign accept   = in_valid && in_ready;
   assign load_en  = accept && (in_op != OP_NOP);

   always_comb begin
      state_d       = state_q;
      flush_done_d  = 1'b0;
      stall_d       = stall_q;
      issue_valid_d = accept;
      id_op_d       = OP_NOP;
      id_vs_d       = id_vs_q;
      id_vt_d       = id_vt_q;
      id_vd_d       = id_vd_q;
      id_shamt_d    = id_shamt_q;
      id_imm_d      = id_imm_q;
      mov_d         = mov_q;
      mem_d         = mem_q;

      case (state_q)
         ST_RUN: begin
            if (flush) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (all_zero) begin
               flush_done_d = 1'b1;
               state_d      = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase

      if (state_q == ST_RUN && in_valid && hazard && stall_q != '1) begin
         stall_d = stall_q + STALL_W'(1);
      end

      if (accept) begin
         id_op_d    = in_op;
         id_vs_d    = in_vs;
         id_vt_d    = in_vt;
         id_vd_d    = in_vd;
         id_shamt_d = in_shamt;
         id_imm_d   = in_imm16;
         mov_d      = in_mov_data;
         mem_d      = in_mem_dir;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_RUN;
         flush_done_q  <= 1'b0;
         stall_q       <= '0;
         issue_valid_q <= 1'b0;
         id_op_q       <= '0;
         id_vs_q       <= '0;
         id_vt_q       <= '0;
         id_vd_q       <= '0;
         id_shamt_q    <= '0;
         id_imm_q      <= '0;
         mov_q         <= '0;
         mem_q         <= '0;
      end else begin
         state_q       <= state_d;
         flush_done_q  <= flush_done_d;
         stall_q       <= stall_d;
         issue_valid_q <= issue_valid_d;
         id_op_q       <= id_op_d;
         id_vs_q       <= id_vs_d;
         id_vt_q       <= id_vt_d;
         id_vd_q       <= id_vd_d;
         id_shamt_q    <= id_shamt_d;
         id_imm_q      <= id_imm_d;
         mov_q         <= mov_d;
         mem_q         <= mem_d;
      end
   end

   assign ID_VS                 = id_vs_q;
   assign ID_VT                 = id_vt_q;
   assign ID_VD                 = id_vd_q;
   assign ID_SHAMT              = id_shamt_q;
   assign ID_OP                 = id_op_q;
   assign ID_IMM16              = id_imm_q;
   assign register_mov_data     = mov_q;
   assign data_memory_direction = mem_q;
   assign issue_valid           = issue_valid_q;
   assign flush_done            = flush_done_q;
   assign stall_count           = stall_q;

endmodule

// File: tb/tb_vector_issue_controller.sv
// Randomised bench: a cycle-level reference model predicts in_ready, issues,
// flush_done and stall_count; a monitor pops expected issues from a queue.
module tb_vector_issue_controller;

   localparam int L  = 3;
   localparam int SW = 16;
   localparam logic [4:0] NOP = 5'b00000;
   localparam logic [4:0] MOV = 5'b00100;
   localparam logic [4:0] ADD = 5'b00010;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [4:0]    in_vs = '0, in_vt = '0, in_vd = '0, in_op = '0;
   logic [11:0]   in_shamt = '0;
   logic [15:0]   in_imm16 = '0;
   logic [31:0]   in_mov_data = '0, in_mem_dir = '0;
   logic          flush = 1'b0;
   logic [4:0]    ID_VS, ID_VT, ID_VD, ID_OP;
   logic [11:0]   ID_SHAMT;
   logic [15:0]   ID_IMM16;
   logic [31:0]   register_mov_data, data_memory_direction;
   logic          issue_valid, flush_done;
   logic [SW-1:0] stall_count;

   vector_issue_controller #(.WB_LATENCY(L), .STALL_W(SW)) dut (
      .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_vs(in_vs), .in_vt(in_vt), .in_vd(in_vd), .in_shamt(in_shamt),
      .in_op(in_op), .in_imm16(in_imm16), .in_mov_data(in_mov_data),
      .in_mem_dir(in_mem_dir), .flush(flush),
      .ID_VS(ID_VS), .ID_VT(ID_VT), .ID_VD(ID_VD), .ID_SHAMT(ID_SHAMT),
      .ID_OP(ID_OP), .ID_IMM16(ID_IMM16), .register_mov_data(register_mov_data),
      .data_memory_direction(data_memory_direction), .issue_valid(issue_valid),
      .flush_done(flush_done), .stall_count(stall_count)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int          cyc;
      logic [4:0]  op, vs, vt, vd;
      logic [11:0] shamt;
      logic [15:0] imm;
      logic [31:0] mov, mem;
   } iss_t;

   iss_t exp_q[$];
   int   fd_q[$];
   int   busy_until[32];
   bit   drain_act = 1'b0;
   int   done_at = 0;
   int   exp_stall = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit reg_busy(input logic [4:0] r, input int c);
      return c < busy_until[r];
   endfunction

   // One clock of stimulus; the model works in absolute cycle numbers:
   // a register written by an instruction accepted in cycle t is free from t+L+1.
   task automatic step(input bit rst, input bit v, input logic [4:0] op,
                       input logic [4:0] vs, input logic [4:0] vt, input logic [4:0] vd,
                       input logic [11:0] sh, input logic [15:0] imm,
                       input logic [31:0] mov, input logic [31:0] mem, input bit fl);
      int   c;
      int   m;
      bit   running, hz, er;
      iss_t e;
      @(posedge clk);
      #2;
      c = cyc;
      if (rst) begin
         reset = 1'b1;
         in_valid = 1'b0;
         flush = 1'b0;
         exp_q.delete();
         fd_q.delete();
         foreach (busy_until[i]) busy_until[i] = 0;
         drain_act = 1'b0;
         exp_stall = 0;
         $display("cycle %0d: reset", c);
         return;
      end
      reset = 1'b0;
      in_valid = v; in_op = op; in_vs = vs; in_vt = vt; in_vd = vd;
      in_shamt = sh; in_imm16 = imm; in_mov_data = mov; in_mem_dir = mem; flush = fl;
      if (drain_act && c >= done_at) drain_act = 1'b0;
      running = !drain_act;
      hz = 1'b0;
      if (op != NOP) begin
         hz = reg_busy(vd, c);
         if (op != MOV) hz = hz | reg_busy(vs, c) | reg_busy(vt, c);
      end
      er = running && !hz;
      #1;
      chk("in_ready", 128'(in_ready), 128'(er));
      if (running && v && hz && exp_stall < (1 << SW) - 1) exp_stall++;
      if (v && er) begin
         e.cyc = c + 1; e.op = op; e.vs = vs; e.vt = vt; e.vd = vd;
         e.shamt = sh; e.imm = imm; e.mov = mov; e.mem = mem;
         exp_q.push_back(e);
         if (op != NOP) busy_until[vd] = c + L + 1;
         $display("cycle %0d: accept op=%b vs=%h vt=%h vd=%h", c, op, vs, vt, vd);
      end
      if (running && fl) begin
         m = c + 2;
         foreach (busy_until[i]) if (busy_until[i] + 1 > m) m = busy_until[i] + 1;
         drain_act = 1'b1;
         done_at = m;
         fd_q.push_back(m);
         $display("cycle %0d: flush, drain done expected cycle %0d", c, m);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, NOP, 5'd0, 5'd0, 5'd0, 12'd0, 16'd0, 32'd0, 32'd0, 0);
   endtask

   function automatic logic [4:0] rreg();
      return 5'($urandom_range(0, 5) * 5);
   endfunction

   function automatic logic [4:0] rop();
      case ($urandom_range(0, 4))
         0: return NOP;
         1: return MOV;
         2: return ADD;
         3: return 5'b01010;
         default: return 5'b10011;
      endcase
   endfunction

   // Monitor: compares every cycle's registered outputs against the queues.
   initial begin
      iss_t last, e;
      bit   rst_e, efd;
      last = '{default: '0};
      forever begin
         @(posedge clk);
         rst_e = reset;
         #1;
         if (rst_e) last = '{default: '0};
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL issue_missing: expected issue in cycle %0d not seen", e.cyc);
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("issue_valid", 128'(issue_valid), 128'(1));
            chk("issue_fields",
                128'({ID_OP, ID_VS, ID_VT, ID_VD, ID_SHAMT, ID_IMM16, register_mov_data, data_memory_direction}),
                128'({e.op, e.vs, e.vt, e.vd, e.shamt, e.imm, e.mov, e.mem}));
            $display("cycle %0d: issue op=%b vd=%h", cyc, ID_OP, ID_VD);
            last = e;
         end else begin
            chk("idle_issue_valid", 128'(issue_valid), 128'(0));
            chk("idle_op", 128'(ID_OP), 128'(NOP));
            chk("idle_hold",
                128'({ID_VS, ID_VT, ID_VD, ID_SHAMT, ID_IMM16, register_mov_data, data_memory_direction}),
                128'({last.vs, last.vt, last.vd, last.shamt, last.imm, last.mov, last.mem}));
         end
         efd = 1'b0;
         if (fd_q.size() > 0 && fd_q[0] == cyc) begin
            void'(fd_q.pop_front());
            efd = 1'b1;
         end
         chk("flush_done", 128'(flush_done), 128'(efd));
         chk("stall_count", 128'(stall_count), 128'(exp_stall));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      step(1, 0, NOP, 5'd0, 5'd0, 5'd0, 12'd0, 16'd0, 32'd0, 32'd0, 0);
      step(1, 0, NOP, 5'd0, 5'd0, 5'd0, 12'd0, 16'd0, 32'd0, 32'd0, 0);
      // Idle after reset, NOP accepted
      step(0, 1, NOP, 5'd0, 5'd0, 5'd0, 12'd0, 16'd0, 32'd0, 32'd0, 0);
      idle(3);
      // MOV V0
      step(0, 1, MOV, 5'd0, 5'd0, 5'b10000, 12'd0, 16'd0, 32'h00010203, 32'd0, 0);
      idle(4);
      // MOV V0 then dependent ADD held valid
      step(1, 0, NOP, 5'd0, 5'd0, 5'd0, 12'd0, 16'd0, 32'd0, 32'd0, 0);
      step(0, 1, MOV, 5'd0, 5'd0, 5'b10000, 12'd0, 16'd0, 32'h00010203, 32'd0, 0);
      for (int i = 0; i < 4; i++)
         step(0, 1, ADD, 5'b10000, 5'b10001, 5'b10100, 12'd7, 16'h1234, 32'd0, 32'h100, 0);
      idle(1);
      chk("stall_after_add", 128'(stall_count), 128'(3));
      idle(4);
      // Independent MOVs on consecutive cycles
      step(0, 1, MOV, 5'd0, 5'd0, 5'b10000, 12'd0, 16'd0, 32'h11, 32'd0, 0);
      step(0, 1, MOV, 5'd0, 5'd0, 5'b10001, 12'd0, 16'd0, 32'h22, 32'd0, 0);
      step(0, 1, MOV, 5'd0, 5'd0, 5'b10010, 12'd0, 16'd0, 32'h33, 32'd0, 0);
      idle(5);
      // MOV V5 with flush, then drain and resume
      step(0, 1, MOV, 5'd0, 5'd0, 5'b10101, 12'd0, 16'd0, 32'h55, 32'd0, 1);
      step(0, 1, MOV, 5'd0, 5'd0, 5'b00001, 12'd0, 16'd0, 32'h66, 32'd0, 0);
      idle(5);
      step(0, 1, MOV, 5'd0, 5'd0, 5'b10101, 12'd0, 16'd0, 32'h77, 32'd0, 0);
      idle(5);
      // Flush with empty scoreboard
      step(0, 0, NOP, 5'd0, 5'd0, 5'd0, 12'd0, 16'd0, 32'd0, 32'd0, 1);
      idle(4);
      // Reset during DRAIN
      step(0, 1, MOV, 5'd0, 5'd0, 5'b10101, 12'd0, 16'd0, 32'h88, 32'd0, 1);
      idle(1);
      step(1, 0, NOP, 5'd0, 5'd0, 5'd0, 12'd0, 16'd0, 32'd0, 32'd0, 0);
      step(0, 1, ADD, 5'b10101, 5'b10101, 5'b10101, 12'd0, 16'd0, 32'd0, 32'd0, 0);
      idle(5);
      // Reset during an active stall
      step(0, 1, MOV, 5'd0, 5'd0, 5'b10000, 12'd0, 16'd0, 32'h99, 32'd0, 0);
      step(0, 1, ADD, 5'b10000, 5'b10001, 5'b10100, 12'd0, 16'd0, 32'd0, 32'd0, 0);
      step(0, 1, ADD, 5'b10000, 5'b10001, 5'b10100, 12'd0, 16'd0, 32'd0, 32'd0, 0);
      step(1, 0, NOP, 5'd0, 5'd0, 5'd0, 12'd0, 16'd0, 32'd0, 32'd0, 0);
      step(0, 1, ADD, 5'b10000, 5'b10001, 5'b10100, 12'd0, 16'd0, 32'd0, 32'd0, 0);
      idle(5);
      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7), rop(),
              rreg(), rreg(), rreg(), 12'($urandom), 16'($urandom),
              32'($urandom), 32'($urandom), ($urandom_range(0, 24) == 0));
      end
      idle(12);
      chk("issue_queue_empty", 128'(exp_q.size()), 128'(0));
      chk("flush_queue_empty", 128'(fd_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
